wb_arbiter: RTL and testbench

- Writeback-stage arbiter that drives the single write port (a3/wd/we) of the register file.
- Merges three result sources onto that port:
  - single-cycle ALU results
  - load results from the LSU
  - multi-cycle mul/div results
- Long-latency results wait in a shared FIFO_D-entry FIFO.
- Write-port outputs are registered; each cycle the file is written at most once.

---
 rtl/wb_arbiter.sv | 124 ++++++++++++
 tb/tb_wb_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - writeback arbiter merging ALU, LSU and mul/div results onto the register file write port
module wb_arbiter #(
    parameter int REG_W  = 5,
    parameter int DATA_W = 32,
    parameter int FIFO_D = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [REG_W-1:0]  alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              lsu_valid,
    output logic              lsu_ready,
    input  logic [REG_W-1:0]  lsu_rd,
    input  logic [DATA_W-1:0] lsu_data,
    input  logic              md_valid,
    output logic              md_ready,
    input  logic [REG_W-1:0]  md_rd,
    input  logic [DATA_W-1:0] md_data,
    output logic              rf_we,
    output logic [REG_W-1:0]  rf_a3,
    output logic [DATA_W-1:0] rf_wd,
    output logic              wb_busy
);

    localparam int PTR_W = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
    localparam int CNT_W = $clog2(FIFO_D + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_D);
    localparam logic [CNT_W:0]   CNT_LIM  = (CNT_W + 1)'(FIFO_D);

    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [REG_W-1:0]  fifo_rd_q   [FIFO_D];
    logic [REG_W-1:0]  fifo_rd_d   [FIFO_D];
    logic [DATA_W-1:0] fifo_data_q [FIFO_D];
    logic [DATA_W-1:0] fifo_data_d [FIFO_D];
    logic              rf_we_q, rf_we_d;
    logic [REG_W-1:0]  rf_a3_q, rf_a3_d;
    logic [DATA_W-1:0] rf_wd_q, rf_wd_d;

    logic fifo_full, fifo_empty;
    logic lsu_hs, md_hs;
    logic push_lsu, push_md;
    logic alu_wr, pop;
    logic [PTR_W-1:0] md_slot;

    // Readies look only at the registered count, so a same-cycle pop never frees a slot early.
    always_comb begin
        fifo_full  = (count_q == CNT_FULL);
        fifo_empty = (count_q == '0);
        alu_ready  = !fifo_full;
        lsu_ready  = !fifo_full;
        lsu_hs     = lsu_valid & lsu_ready;
        md_ready   = (({1'b0, count_q} + (CNT_W + 1)'(lsu_hs)) < CNT_LIM);
        md_hs      = md_valid & md_ready;
        push_lsu   = lsu_hs & (lsu_rd != '0);
        push_md    = md_hs & (md_rd != '0);
        alu_wr     = alu_valid & !fifo_full & (alu_rd != '0);
        pop        = !fifo_empty & !alu_wr;
        md_slot    = push_lsu ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    end

    always_comb begin
        fifo_rd_d   = fifo_rd_q;
        fifo_data_d = fifo_data_q;
        if (push_lsu) begin
            fifo_rd_d[wr_ptr_q]   = lsu_rd;
            fifo_data_d[wr_ptr_q] = lsu_data;
        end
        if (push_md) begin
            fifo_rd_d[md_slot]   = md_rd;
            fifo_data_d[md_slot] = md_data;
        end
        wr_ptr_d = wr_ptr_q + PTR_W'(push_lsu) + PTR_W'(push_md);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + CNT_W'(push_lsu) + CNT_W'(push_md) - CNT_W'(pop);
    end

    // Address and data hold their last values when nothing is written.
    always_comb begin
        rf_we_d = alu_wr | pop;
        rf_a3_d = rf_a3_q;
        rf_wd_d = rf_wd_q;
        if (pop) begin
            rf_a3_d = fifo_rd_q[rd_ptr_q];
            rf_wd_d = fifo_data_q[rd_ptr_q];
        end else if (alu_wr) begin
            rf_a3_d = alu_rd;
            rf_wd_d = alu_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            rf_we_q  <= 1'b0;
            rf_a3_q  <= '0;
            rf_wd_q  <= '0;
            for (int i = 0; i < FIFO_D; i++) begin
                fifo_rd_q[i]   <= '0;
                fifo_data_q[i] <= '0;
            end
        end else begin
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            rf_we_q     <= rf_we_d;
            rf_a3_q     <= rf_a3_d;
            rf_wd_q     <= rf_wd_d;
            fifo_rd_q   <= fifo_rd_d;
            fifo_data_q <= fifo_data_d;
        end
    end

    assign rf_we   = rf_we_q;
    assign rf_a3   = rf_a3_q;
    assign rf_wd   = rf_wd_q;
    assign wb_busy = !fifo_empty;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - directed scoreboard bench for wb_arbiter
module tb_wb_arbiter;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    logic        clk;
    logic        rst_n;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lsu_valid, lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        md_valid, md_ready;
    logic [4:0]  md_rd;
    logic [31:0] md_data;
    logic        rf_we;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd;
    logic        wb_busy;

    int  vectors;
    int  miscompares;
    wr_t exp_q[$];

    wb_arbiter #(.REG_W(5), .DATA_W(32), .FIFO_D(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .md_valid(md_valid), .md_ready(md_ready), .md_rd(md_rd), .md_data(md_data),
        .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd(rf_wd), .wb_busy(wb_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
        md_valid  = 1'b0; md_rd  = '0; md_data  = '0;
    endtask

    task automatic drive_alu(input logic [4:0] rd, input logic [31:0] d);
        alu_valid = 1'b1; alu_rd = rd; alu_data = d;
    endtask

    task automatic drive_lsu(input logic [4:0] rd, input logic [31:0] d);
        lsu_valid = 1'b1; lsu_rd = rd; lsu_data = d;
    endtask

    task automatic drive_md(input logic [4:0] rd, input logic [31:0] d);
        md_valid = 1'b1; md_rd = rd; md_data = d;
    endtask

    task automatic expect_wr(input logic [4:0] rd, input logic [31:0] d);
        exp_q.push_back('{rd: rd, data: d});
    endtask

    // Every register-file write is popped against the expected write order.
    always @(negedge clk) begin
        if (rf_we === 1'b1) begin
            chk("we_nonzero_rd", 64'(rf_a3 != 5'd0), 64'd1);
            chk("sb_pending", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                wr_t e;
                e = exp_q.pop_front();
                chk("sb_a3", 64'(rf_a3), 64'(e.rd));
                chk("sb_wd", 64'(rf_wd), 64'(e.data));
            end
        end
    end

    initial begin
        vectors = 0;
        miscompares = 0;
        idle();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #10;
        chk("rst_we", 64'(rf_we), 64'd0);
        chk("rst_a3", 64'(rf_a3), 64'd0);
        chk("rst_wd", 64'(rf_wd), 64'd0);
        chk("rst_busy", 64'(wb_busy), 64'd0);
        chk("rst_alu_ready", 64'(alu_ready), 64'd1);
        chk("rst_lsu_ready", 64'(lsu_ready), 64'd1);
        chk("rst_md_ready", 64'(md_ready), 64'd1);
        tick();
        rst_n = 1'b1;

        // ALU single-cycle write
        drive_alu(5'd5, 32'h1234);
        expect_wr(5'd5, 32'h1234);
        #1 chk("alu_ready", 64'(alu_ready), 64'd1);
        tick();
        idle();
        chk("alu_we", 64'(rf_we), 64'd1);
        chk("alu_a3", 64'(rf_a3), 64'd5);
        chk("alu_wd", 64'(rf_wd), 64'h1234);
        tick();
        chk("alu_we_drop", 64'(rf_we), 64'd0);
        chk("alu_hold_a3", 64'(rf_a3), 64'd5);

        // LSU and MD together
        drive_lsu(5'd7, 32'hAA);
        drive_md(5'd9, 32'hBB);
        expect_wr(5'd7, 32'hAA);
        expect_wr(5'd9, 32'hBB);
        #1;
        chk("dual_lsu_ready", 64'(lsu_ready), 64'd1);
        chk("dual_md_ready", 64'(md_ready), 64'd1);
        tick();
        idle();
        #1;
        chk("dual_busy", 64'(wb_busy), 64'd1);
        chk("dual_full_alu_ready", 64'(alu_ready), 64'd0);
        chk("dual_full_lsu_ready", 64'(lsu_ready), 64'd0);
        tick();
        chk("dual_first_a3", 64'(rf_a3), 64'd7);
        tick();
        chk("dual_second_a3", 64'(rf_a3), 64'd9);
        chk("dual_busy_clear", 64'(wb_busy), 64'd0);
        tick();
        chk("dual_idle_we", 64'(rf_we), 64'd0);

        // Full FIFO holds off a continuous ALU result
        drive_lsu(5'd10, 32'h100);
        drive_md(5'd11, 32'h200);
        expect_wr(5'd10, 32'h100);
        tick();
        idle();
        drive_alu(5'd3, 32'h11);
        #1 chk("hold_alu_ready_full", 64'(alu_ready), 64'd0);
        tick();
        chk("hold_alu_ready_free", 64'(alu_ready), 64'd1);
        expect_wr(5'd3, 32'h11);
        tick();
        idle();
        expect_wr(5'd11, 32'h200);
        tick();
        tick();
        chk("hold_done_we", 64'(rf_we), 64'd0);
        chk("hold_done_busy", 64'(wb_busy), 64'd0);

        // x0 destinations are accepted but never written
        drive_alu(5'd0, 32'h77);
        drive_lsu(5'd0, 32'h55);
        drive_md(5'd0, 32'h66);
        #1;
        chk("x0_alu_ready", 64'(alu_ready), 64'd1);
        chk("x0_lsu_ready", 64'(lsu_ready), 64'd1);
        chk("x0_md_ready", 64'(md_ready), 64'd1);
        tick();
        idle();
        chk("x0_busy", 64'(wb_busy), 64'd0);
        chk("x0_we", 64'(rf_we), 64'd0);
        tick();
        chk("x0_we_later", 64'(rf_we), 64'd0);

        // Three loads behind an ALU stream, pointers wrap
        drive_alu(5'd20, 32'h20);
        drive_lsu(5'd1, 32'h1);
        expect_wr(5'd20, 32'h20);
        #1;
        chk("wrap_c0_alu_ready", 64'(alu_ready), 64'd1);
        chk("wrap_c0_lsu_ready", 64'(lsu_ready), 64'd1);
        tick();
        drive_alu(5'd21, 32'h21);
        drive_lsu(5'd2, 32'h2);
        expect_wr(5'd21, 32'h21);
        #1 chk("wrap_c1_lsu_ready", 64'(lsu_ready), 64'd1);
        tick();
        drive_alu(5'd22, 32'h22);
        drive_lsu(5'd3, 32'h3);
        expect_wr(5'd1, 32'h1);
        #1;
        chk("wrap_c2_lsu_ready", 64'(lsu_ready), 64'd0);
        chk("wrap_c2_alu_ready", 64'(alu_ready), 64'd0);
        chk("wrap_c2_busy", 64'(wb_busy), 64'd1);
        tick();
        expect_wr(5'd22, 32'h22);
        chk("wrap_c3_lsu_ready", 64'(lsu_ready), 64'd1);
        chk("wrap_c3_alu_ready", 64'(alu_ready), 64'd1);
        tick();
        idle();
        drive_alu(5'd23, 32'h23);
        expect_wr(5'd2, 32'h2);
        #1 chk("wrap_c4_alu_ready", 64'(alu_ready), 64'd0);
        tick();
        expect_wr(5'd23, 32'h23);
        chk("wrap_c5_alu_ready", 64'(alu_ready), 64'd1);
        tick();
        idle();
        expect_wr(5'd3, 32'h3);
        tick();
        tick();
        chk("wrap_done_we", 64'(rf_we), 64'd0);
        chk("wrap_done_busy", 64'(wb_busy), 64'd0);

        // Asynchronous reset with a full FIFO mid-drain
        drive_alu(5'd15, 32'h15);
        drive_lsu(5'd12, 32'hC12);
        drive_md(5'd13, 32'hC13);
        tick();
        idle();
        chk("areset_pre_we", 64'(rf_we), 64'd1);
        chk("areset_pre_a3", 64'(rf_a3), 64'd15);
        chk("areset_pre_busy", 64'(wb_busy), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("areset_we", 64'(rf_we), 64'd0);
        chk("areset_a3", 64'(rf_a3), 64'd0);
        chk("areset_busy", 64'(wb_busy), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_reset_we", 64'(rf_we), 64'd0);
            chk("post_reset_busy", 64'(wb_busy), 64'd0);
        end

        chk("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
